// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters with registered sync, DE and line/frame pulses.
// Optional colour-bar test pattern on r/g/b when VIDEO_TIMING_BARS_EN is defined.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $fatal(1, "video_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $fatal(1, "video_timing_gen: V_TOTAL exceeds 1024");
    end

    localparam logic [9:0]  HMax      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VMax      = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync ending exactly at 1024 still compares correctly
    localparam logic [10:0] HActEnd   = 11'(H_ACTIVE);
    localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VActEnd   = 11'(V_ACTIVE);
    localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [10:0] x_ext, y_ext;
    logic        de_q, de_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    // Outputs are decoded from the next counter value so they align with x/y.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == HMax) begin
            x_d = '0;
            y_d = (y_q == VMax) ? '0 : y_q + 10'd1;
        end
        x_ext         = {1'b0, x_d};
        y_ext         = {1'b0, y_d};
        de_d          = (x_ext < HActEnd) && (y_ext < VActEnd);
        hsync_d       = ((x_ext >= HSyncBeg) && (x_ext < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((y_ext >= VSyncBeg) && (y_ext < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = (x_d == '0);
        frame_start_d = (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q           <= HMax;
            y_q           <= VMax;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (ena_i) begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

`ifdef VIDEO_TIMING_BARS_EN
    logic [2:0]  bar;
    logic [2:0]  rgb_bits;
    logic [23:0] rgb_q, rgb_d;

    // Bar index by threshold comparison; avoids a divider.
    always_comb begin
        bar = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if ({22'd0, x_d} >= k * (H_ACTIVE / 8)) begin
                bar = 3'(k);
            end
        end
        unique case (bar)
            3'd0: rgb_bits = 3'b111;
            3'd1: rgb_bits = 3'b110;
            3'd2: rgb_bits = 3'b011;
            3'd3: rgb_bits = 3'b010;
            3'd4: rgb_bits = 3'b101;
            3'd5: rgb_bits = 3'b100;
            3'd6: rgb_bits = 3'b001;
            3'd7: rgb_bits = 3'b000;
            default: rgb_bits = 3'b000;
        endcase
        rgb_d = de_d ? {{8{rgb_bits[2]}}, {8{rgb_bits[1]}}, {8{rgb_bits[0]}}} : 24'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q <= 24'd0;
        end else if (ena_i) begin
            rgb_q <= rgb_d;
        end
    end

    assign r_o = rgb_q[23:16];
    assign g_o = rgb_q[15:8];
    assign b_o = rgb_q[7:0];
`else
    assign r_o = 8'd0;
    assign g_o = 8'd0;
    assign b_o = 8'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-mode instance plus a small active-high-sync instance,
// checked each cycle against a linear raster-position model and directed literal checks.
module tb_video_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } obs_t;

    // Small mode: 80 x 55 total, 4400 pixels per frame, active-high syncs.
    localparam int SHA = 64, SHF = 4, SHS = 8, SHB = 4;
    localparam int SVA = 48, SVF = 2, SVS = 2, SVB = 3;
    localparam int DFR = 800 * 525;
    localparam int SFR = 80 * 55;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d_n = 1'b1, ena_d = 1'b1, rst_s_n = 1'b1, ena_s = 1'b1;
    logic       d_hs, d_vs, d_de, d_ls, d_fs, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic [7:0] d_r, d_g, d_b, s_r, s_g, s_b;

    int unsigned n_chk = 0, n_fail = 0;
    int          p_d, p_s;
    logic [2:0]  bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    video_timing_gen u_dflt (
        .clk_i(clk), .rst_ni(rst_d_n), .ena_i(ena_d),
        .hsync_o(d_hs), .vsync_o(d_vs), .de_o(d_de), .x_o(d_x), .y_o(d_y),
        .line_start_o(d_ls), .frame_start_o(d_fs), .r_o(d_r), .g_o(d_g), .b_o(d_b)
    );

    video_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)
    ) u_small (
        .clk_i(clk), .rst_ni(rst_s_n), .ena_i(ena_s),
        .hsync_o(s_hs), .vsync_o(s_vs), .de_o(s_de), .x_o(s_x), .y_o(s_y),
        .line_start_o(s_ls), .frame_start_o(s_fs), .r_o(s_r), .g_o(s_g), .b_o(s_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs from a linear raster position p (reset == position frame-1).
    function automatic obs_t model(input int p, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb, input bit pol);
        obs_t e;
        int   ht, px, py, idx;
        ht   = ha + hf + hsw + hb;
        px   = p % ht;
        py   = p / ht;
        e.x  = 10'(px);
        e.y  = 10'(py);
        e.de = (px < ha) && (py < va);
        e.hs = (px >= ha + hf && px < ha + hf + hsw) ? pol : !pol;
        e.vs = (py >= va + vf && py < va + vf + vsw) ? pol : !pol;
        e.ls = (px == 0);
        e.fs = (p == 0);
        e.r  = 8'd0;
        e.g  = 8'd0;
        e.b  = 8'd0;
`ifdef VIDEO_TIMING_BARS_EN
        if (e.de) begin
            idx = px / (ha / 8);
            if (idx > 7) idx = 7;
            e.r = {8{bar_tab[idx][2]}};
            e.g = {8{bar_tab[idx][1]}};
            e.b = {8{bar_tab[idx][0]}};
        end
`else
        idx = 0;
`endif
        return e;
    endfunction

    task automatic cmp_all(input string pre, input obs_t a, input obs_t e);
        chk({pre, ".x"}, 32'(a.x), 32'(e.x));
        chk({pre, ".y"}, 32'(a.y), 32'(e.y));
        chk({pre, ".de"}, 32'(a.de), 32'(e.de));
        chk({pre, ".hsync"}, 32'(a.hs), 32'(e.hs));
        chk({pre, ".vsync"}, 32'(a.vs), 32'(e.vs));
        chk({pre, ".line_start"}, 32'(a.ls), 32'(e.ls));
        chk({pre, ".frame_start"}, 32'(a.fs), 32'(e.fs));
        chk({pre, ".rgb"}, {8'd0, a.r, a.g, a.b}, {8'd0, e.r, e.g, e.b});
    endtask

    always @(posedge clk or negedge rst_d_n) begin
        if (!rst_d_n) p_d <= DFR - 1;
        else if (ena_d) p_d <= (p_d + 1) % DFR;
    end

    always @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) p_s <= SFR - 1;
        else if (ena_s) p_s <= (p_s + 1) % SFR;
    end

    always @(negedge clk) begin
        cmp_all("dflt", {d_hs, d_vs, d_de, d_ls, d_fs, d_x, d_y, d_r, d_g, d_b},
                model(p_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        cmp_all("small", {s_hs, s_vs, s_de, s_ls, s_fs, s_x, s_y, s_r, s_g, s_b},
                model(p_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1));
    end

    function automatic logic [23:0] bar_lit(input int px);
`ifdef VIDEO_TIMING_BARS_EN
        case (px)
            0:       return 24'hFFFFFF;
            80:      return 24'hFFFF00;
            400:     return 24'hFF0000;
            default: return 24'h000000;
        endcase
`else
        return (px < 0) ? 24'hFFFFFF : 24'h000000;
`endif
    endfunction

    initial begin
        int hs_cnt, hs_first, hs_last, de_cnt, t, cyc, vcnt;
        logic prev_vs;

        #1 rst_d_n = 1'b0;
        rst_s_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.x", 32'(d_x), 799);
        chk("rst.y", 32'(d_y), 524);
        chk("rst.de", 32'(d_de), 0);
        chk("rst.hsync", 32'(d_hs), 1);
        chk("rst.vsync", 32'(d_vs), 1);
        chk("rst.pulses", {30'd0, d_ls, d_fs}, 0);
        chk("rst.small_hsync", 32'(s_hs), 0);

        rst_d_n = 1'b1;
        rst_s_n = 1'b1;
        @(negedge clk);
        chk("first.x", 32'(d_x), 0);
        chk("first.y", 32'(d_y), 0);
        chk("first.de", 32'(d_de), 1);
        chk("first.frame_start", 32'(d_fs), 1);
        chk("first.line_start", 32'(d_ls), 1);

        // Line 0 of the default mode.
        hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (d_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_x);
                hs_last = int'(d_x);
            end
            if (d_de) de_cnt++;
            if (d_x == 10'd640) chk("de_at_640", 32'(d_de), 0);
            if (d_x == 10'd0 || d_x == 10'd80 || d_x == 10'd400 || d_x == 10'd639 ||
                d_x == 10'd640)
                chk($sformatf("bar_x%0d", d_x), {8'd0, d_r, d_g, d_b},
                    {8'd0, bar_lit(int'(d_x))});
            @(negedge clk);
        end
        chk("hsync_width", hs_cnt, 96);
        chk("hsync_first_x", hs_first, 656);
        chk("hsync_last_x", hs_last, 751);
        chk("de_width", de_cnt, 640);
        chk("wrap.x", 32'(d_x), 0);
        chk("wrap.y", 32'(d_y), 1);
        chk("wrap.line_start", 32'(d_ls), 1);
        chk("wrap.frame_start", 32'(d_fs), 0);

        // Clock-enable freeze at (100,5).
        t = 0;
        while (!(d_x == 10'd100 && d_y == 10'd5) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_100_5_timeout", 32'(t >= 5000), 0);
        ena_d = 1'b0;
        repeat (37) begin
            @(negedge clk);
            chk("frozen.x", 32'(d_x), 100);
            chk("frozen.y", 32'(d_y), 5);
        end
        ena_d = 1'b1;
        @(negedge clk);
        chk("resume.x", 32'(d_x), 101);
        chk("resume.y", 32'(d_y), 5);

        // Frame period and vsync on the small mode.
        t = 0;
        while (!s_fs && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_fs_timeout", 32'(t >= 5000), 0);
        cyc = 0; vcnt = 0; prev_vs = s_vs;
        do begin
            @(negedge clk);
            cyc++;
            if (s_vs) vcnt++;
            if (s_vs != prev_vs) chk("vsync_edge_x", 32'(s_x), 0);
            prev_vs = s_vs;
        end while (!s_fs && cyc < 10000);
        chk("frame_period", cyc, 4400);
        chk("vsync_cycles", vcnt, 160);

        // Asynchronous mid-frame reset on the small mode at (30,20).
        t = 0;
        while (!(s_x == 10'd30 && s_y == 10'd20) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_30_20_timeout", 32'(t >= 5000), 0);
        #2 rst_s_n = 1'b0;
        #1;
        chk("async.x", 32'(s_x), 79);
        chk("async.y", 32'(s_y), 54);
        chk("async.de", 32'(s_de), 0);
        chk("async.hsync", 32'(s_hs), 0);
        chk("async.vsync", 32'(s_vs), 0);
        @(negedge clk);
        rst_s_n = 1'b1;
        @(negedge clk);
        chk("restart.x", 32'(s_x), 0);
        chk("restart.y", 32'(s_y), 0);
        chk("restart.frame_start", 32'(s_fs), 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the HDMI output path. Runs on the pixel clock and produces `hsync`, `vsync`, `de` and the current pixel coordinates. The pixel-source logic uses the coordinates to fetch colour. The three TMDS channel encoders consume `de`/`hsync`/`vsync`. Default parameters give 640x480@60 (800x525 total, 25.2 MHz pixel clock); other modes are set by parameters.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, pixels
- `H_SYNC`, 96, horizontal sync width, pixels
- `H_BP`, 48, horizontal back porch, pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, lines
- `V_SYNC`, 2, vertical sync width, lines
- `V_BP`, 33, vertical back porch, lines
- `SYNC_POL`, 0, sync output polarity (0 = active-low, 1 = active-high)
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `ena`  in  1  clock enable; all state holds while low
- `hsync`  out  1  horizontal sync, polarity per `SYNC_POL`
- `vsync`  out  1  vertical sync, polarity per `SYNC_POL`
- `de`  out  1  display enable, high for active pixels only
- `x`  out  10  horizontal counter, 0..H_TOTAL-1
- `y`  out  10  vertical counter, 0..V_TOTAL-1
- `line_start`  out  1  one-cycle pulse when x==0
- `frame_start`  out  1  one-cycle pulse when x==0 and y==0
- `r`, `g`, `b`  out  8 each  test-pattern colour (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V_ parameters.
- Both totals must be ≤1024. This is an elaboration-time check that raises a fatal error.
- Counters:
  - On each `clk` rising edge with `ena`=1, `x` increments.
  - At x==H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - At x==H_TOTAL-1 and y==V_TOTAL-1, both wrap to 0.
- Decode conditions. These are evaluated on the counter's next value, so that each output is aligned with `x`/`y` in the same cycle:
  - `de` = (x<H_ACTIVE) && (y<V_ACTIVE).
  - hsync active when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC. Because it is decoded from `y`, vsync edges coincide with x==0.
  - Active sync level = `SYNC_POL`; inactive level = ~`SYNC_POL`.
- All outputs come straight from flops. There is no combinational path from `ena` to any output.
- `ena`=0 freezes every register, pulses included: a pulse that was high stays high while frozen. Consumers qualify pulses with `ena`.

## Timing
- Reset (asynchronous assert, synchronous release on `clk`):
  - x=H_TOTAL-1, y=V_TOTAL-1
  - `de`=0, `hsync`=`vsync`=~`SYNC_POL`
  - `line_start`=`frame_start`=0, `r`=`g`=`b`=0
- First enabled edge after reset: x=0, y=0, `de`=1, `line_start`=`frame_start`=1.
- Latency: every output reflects the (x,y) shown in the same cycle (zero relative skew).
- Line period is H_TOTAL enabled cycles; frame period is H_TOTAL*V_TOTAL enabled cycles (420000 by default).
- `rst_n` asserted mid-frame: outputs return to reset values immediately, with no wait for `clk`.

## Configuration
- Macro `VIDEO_TIMING_BARS_EN`.
- Defined: built-in colour-bar pattern on `r`/`g`/`b`.
  - Eight vertical bars, each H_ACTIVE/8 pixels wide, in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Channel values are 8'hFF or 8'h00 only.
  - Bar index comes from comparisons of x against multiples of H_ACTIVE/8. No divider is used.
  - `r`=`g`=`b`=0 whenever `de`=0.
  - Colour is registered with the same alignment as `de`.
- Not defined: `r`, `g`, `b` are tied to 0, and no bar logic is synthesised. The ports remain present.

## Test plan
- Reset and first frame, default parameters: hold `rst_n`=0 → de=0, hsync=vsync=1, x=799, y=524. Release `rst_n`, then one enabled edge → x=0, y=0, de=1, frame_start=1, line_start=1.
- Horizontal sync on line 0: hsync low exactly for x=656..751 (96 cycles). de high for x=0..639 and low at x=640. At x=799→0: y goes 0→1 and line_start=1.
- Vertical sync and frame wrap: vsync low for lines 490..491, i.e. 1600 cycles, with edges at x==0. The next frame_start occurs exactly 420000 enabled cycles after the previous one.
- Clock enable: hold `ena`=0 for 37 cycles at x=100, y=5 → all outputs unchanged. Resume → x=101 on the next edge.
- Mid-frame reset: pulse `rst_n` low at x=300, y=200 → outputs go to reset values before the next `clk` edge. After release, counting restarts with the first enabled edge at (0,0).
- With `VIDEO_TIMING_BARS_EN`:

  | x   | expected colour          |
  |-----|--------------------------|
  | 0   | FF/FF/FF (white)         |
  | 80  | FF/FF/00 (yellow)        |
  | 400 | FF/00/00 (red)           |
  | 639 | 00/00/00 (black)         |
  | 640 | 0/0/0 (blanking)         |

  Without the macro, `r`/`g`/`b` are 0 at every cycle.
